// File: rtl/pe_vec_mac_if.sv
// Beat/result bus of the vector MAC: configuration, ifmap/weight/bias beat input,
// opsum result output, plus busy and the FSM state for observation.
interface pe_vec_mac_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  // Handshake: a beat moves when in_valid & in_ready; a result moves when
  // out_valid & out_ready. A source holds its payload stable while valid is
  // high and ready is low; valid never waits on ready.
  logic [CNT_W-1:0]        cfg_len;
  logic                    cfg_signed;
  logic                    cfg_relu;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] ifmap;
  logic [LANES*DATA_W-1:0] weight;
  logic [ACC_W-1:0]        bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        opsum;
  logic                    busy;
  logic [1:0]              state_dbg;

  modport master (
    output cfg_len, cfg_signed, cfg_relu, in_valid, ifmap, weight, bias, out_ready,
    input  in_ready, out_valid, opsum, busy, state_dbg
  );

  modport slave (
    input  cfg_len, cfg_signed, cfg_relu, in_valid, ifmap, weight, bias, out_ready,
    output in_ready, out_valid, opsum, busy, state_dbg
  );
endinterface

// File: rtl/pe_vec_mac.sv
// Vector MAC processing element: LANES products per beat summed into one
// accumulator over cfg_len beats, seeded with bias, optional ReLU on the result.
module pe_vec_mac #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  pe_vec_mac_if.slave   bus
);
  localparam int PW = 2*DATA_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len_q, cnt;
  logic              signed_q, relu_q;
  logic [ACC_W-1:0]  acc, dot, acc_nxt;
  logic              accept, use_signed, relu_eff, last_beat;

  logic signed [DATA_W:0] lane_a, lane_b;
  logic signed [PW-1:0]   prod;

  assign accept     = bus.in_valid & bus.in_ready;
  assign use_signed = (state == IDLE) ? bus.cfg_signed : signed_q;
  // ReLU only makes sense for signed results; an unsigned MSB is magnitude.
  assign relu_eff   = (state == IDLE) ? (bus.cfg_relu & bus.cfg_signed) : (relu_q & signed_q);
  assign last_beat  = (state == IDLE) ? (bus.cfg_len <= CNT_W'(1))
                                      : ((cnt + CNT_W'(1)) == len_q);
  assign acc_nxt    = ((state == IDLE) ? bus.bias : acc) + dot;
  assign bus.state_dbg = state;

  // One extra bit per operand lets signed and unsigned lanes share a signed multiply.
  always_comb begin
    dot    = '0;
    lane_a = '0;
    lane_b = '0;
    prod   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = {use_signed & bus.ifmap[i*DATA_W + DATA_W-1],  bus.ifmap[i*DATA_W +: DATA_W]};
      lane_b = {use_signed & bus.weight[i*DATA_W + DATA_W-1], bus.weight[i*DATA_W +: DATA_W]};
      prod   = lane_a * lane_b;
      dot    = dot + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = last_beat ? DONE : ACC;
      end
      ACC: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid && last_beat) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      signed_q  <= 1'b0;
      relu_q    <= 1'b0;
      bus.opsum <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      if (state == IDLE) begin
        cnt      <= CNT_W'(1);
        len_q    <= (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
        signed_q <= bus.cfg_signed;
        relu_q   <= bus.cfg_relu;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Result is captured on the DONE entry edge so it is stable for the whole DONE stay.
      if (last_beat) bus.opsum <= (relu_eff && acc_nxt[ACC_W-1]) ? '0 : acc_nxt;
    end
  end
endmodule

// File: tb/tb_pe_vec_mac.sv
// Directed bench for pe_vec_mac: hand-computed vectors covering latency,
// signed/unsigned lanes, ReLU, back-pressure, input gaps, wrap and mid-run reset.
module tb_pe_vec_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pe_vec_mac_if #(.DATA_W(8), .LANES(4), .ACC_W(32), .CNT_W(8)) bus ();

  pe_vec_mac #(.DATA_W(8), .LANES(4), .ACC_W(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.cfg_len    = 8'd1;
    bus.cfg_signed = 1'b0;
    bus.cfg_relu   = 1'b0;
    bus.ifmap      = '0;
    bus.weight     = '0;
    bus.bias       = '0;
  endtask

  // Present one beat at a negedge and return just after the accepting posedge.
  task automatic send_beat(input logic [31:0] ifm, input logic [31:0] wgt, input logic [31:0] b,
                           input logic [7:0] len, input logic sgn, input logic relu);
    int n;
    @(negedge clk);
    bus.ifmap = ifm; bus.weight = wgt; bus.bias = b;
    bus.cfg_len = len; bus.cfg_signed = sgn; bus.cfg_relu = relu;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait for a result, compare it, then consume it with a single out_ready pulse.
  task automatic take_result(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.opsum, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_opsum",     bus.opsum,          32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_state",     32'(bus.state_dbg), 32'd0);

    // 1: unsigned len=1, 4+3+2+1+10 = 20, out_valid one cycle after accept
    send_beat(32'h04030201, 32'h01010101, 32'd10, 8'd1, 1'b0, 1'b0);
    check("t1_latency_valid", 32'(bus.out_valid), 32'd1);
    check("t1_in_ready_done", 32'(bus.in_ready),  32'd0);
    check("t1_busy",          32'(bus.busy),      32'd1);
    take_result("t1_opsum", 32'd20);
    check("t1_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t1_busy_drop",  32'(bus.busy),      32'd0);
    check("t1_opsum_hold", bus.opsum,          32'd20);

    // 2: signed, 3 beats of 4*(-1*2) = -24; later-beat bias must be ignored
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd0,   8'd3, 1'b1, 1'b0);
    check("t2_mid_valid", 32'(bus.out_valid), 32'd0);
    check("t2_mid_busy",  32'(bus.busy),      32'd1);
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd100, 8'd3, 1'b1, 1'b0);
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd100, 8'd3, 1'b1, 1'b0);
    take_result("t2_signed", 32'hFFFFFFE8);
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd0, 8'd3, 1'b1, 1'b1);
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd0, 8'd3, 1'b1, 1'b1);
    send_beat(32'hFFFFFFFF, 32'h02020202, 32'd0, 8'd3, 1'b1, 1'b1);
    take_result("t2_relu", 32'd0);
    // ReLU ignored for unsigned: 0x80000000 bias stays
    send_beat(32'h0, 32'h0, 32'h80000000, 8'd1, 1'b0, 1'b1);
    take_result("t2_relu_unsigned", 32'h80000000);

    // 3: back-pressure for 5 cycles with a competing beat offered: 4*(1*5) = 20
    send_beat(32'h01010101, 32'h05050505, 32'd0, 8'd1, 1'b0, 1'b0);
    bus.ifmap = 32'hFFFFFFFF; bus.weight = 32'hFFFFFFFF; bus.bias = 32'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_opsum", bus.opsum,          32'd20);
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    take_result("t3_opsum", 32'd20);
    send_beat(32'h00000003, 32'h00000004, 32'd1, 8'd1, 1'b0, 1'b0);
    take_result("t3_next", 32'd13);

    // 4: len=4 gap-free; 5 + 10 + 128 + 510 + 7 = 660
    send_beat(32'h01020304, 32'h01010101, 32'd5, 8'd4, 1'b0, 1'b0);
    send_beat(32'h10101010, 32'h02020202, 32'd0, 8'd4, 1'b0, 1'b0);
    send_beat(32'hFF000000, 32'h02000000, 32'd0, 8'd4, 1'b0, 1'b0);
    send_beat(32'h00000001, 32'h00000007, 32'd0, 8'd4, 1'b0, 1'b0);
    take_result("t4_nogap", 32'd660);
    // same data with random bubbles and cfg changes after the first beat
    send_beat(32'h01020304, 32'h01010101, 32'd5, 8'd4, 1'b0, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_beat(32'h10101010, 32'h02020202, 32'd9, 8'd1, 1'b1, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check("t4_gap_valid", 32'(bus.out_valid), 32'd0);
    send_beat(32'hFF000000, 32'h02000000, 32'd9, 8'd1, 1'b1, 1'b1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_beat(32'h00000001, 32'h00000007, 32'd9, 8'd2, 1'b1, 1'b1);
    take_result("t4_gap", 32'd660);
    // cfg_len=0 acts as 1: 2*3 + 1 = 7
    send_beat(32'h00000002, 32'h00000003, 32'd1, 8'd0, 1'b0, 1'b0);
    check("t4_len0_valid", 32'(bus.out_valid), 32'd1);
    take_result("t4_len0", 32'd7);

    // 5: 0xFFFFFFFF + 1 wraps to 0
    send_beat(32'h00000001, 32'h00000001, 32'hFFFFFFFF, 8'd1, 1'b0, 1'b0);
    take_result("t5_wrap", 32'd0);

    // 6: reset after 2 of 4 beats, with a beat offered during reset
    send_beat(32'h01010101, 32'h01010101, 32'd50, 8'd4, 1'b0, 1'b0);
    send_beat(32'h01010101, 32'h01010101, 32'd50, 8'd4, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.bias = 32'd99; bus.cfg_len = 8'd1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_opsum", bus.opsum,          32'd0);
    check("t6_busy",  32'(bus.busy),      32'd0);
    check("t6_state", 32'(bus.state_dbg), 32'd0);
    send_beat(32'h04030201, 32'h01010101, 32'd10, 8'd1, 1'b0, 1'b0);
    take_result("t6_golden", 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
